// File: rtl/alu_mdu_unit_pkg.sv
// Shared types for the ALU / multiply-divide execution unit.
// Operation names, FSM states and small operation-class helpers.
package alu_mdu_unit_pkg;

  typedef enum logic [5:0] {
    ADD, ADDI, SUB, SLT, SLTI, SLTU, SLTIU,
    XOR, XORI, OR, ORI, AND, ANDI,
    SLL, SLLI, SRL, SRLI, SRA, SRAI,
    LUI, AUIPC,
    MUL, MULH, MULHSU, MULHU,
    DIV, DIVU, REM, REMU,
    LW, SW, BEQ, JAL
  } instr_name_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_MUL,
    BUSY_DIV,
    DONE
  } alu_mdu_state_e;

  function automatic logic is_mul_op(input instr_name_e op);
    return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == MULHU);
  endfunction

  function automatic logic is_div_op(input instr_name_e op);
    return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/alu_mdu_unit_alu_core.sv
// Combinational evaluator for the single-cycle integer ALU operations.
// is_alu drops low for any operation this block does not handle.
module alu_core
  import alu_mdu_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  instr_name_e       instr_name,
  input  logic [XLEN-1:0]   data_1,
  input  logic [XLEN-1:0]   data_2,
  input  logic [XLEN-1:0]   address,
  input  logic [XLEN-1:0]   immediate,
  output logic [XLEN-1:0]   result,
  output logic              is_alu
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0]        op_b;
  logic [SHW-1:0]         shamt;
  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;

  // I-type forms take the immediate in place of rs2
  always_comb begin
    op_b = data_2;
    case (instr_name)
      ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI: op_b = immediate;
      default: op_b = data_2;
    endcase
  end

  assign shamt = op_b[SHW-1:0];
  assign a_s   = data_1;
  assign b_s   = op_b;

  always_comb begin
    result = '0;
    is_alu = 1'b1;
    case (instr_name)
      ADD, ADDI:   result = data_1 + op_b;
      SUB:         result = data_1 - op_b;
      SLT, SLTI:   result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      SLTU, SLTIU: result = {{(XLEN-1){1'b0}}, (data_1 < op_b)};
      XOR, XORI:   result = data_1 ^ op_b;
      OR, ORI:     result = data_1 | op_b;
      AND, ANDI:   result = data_1 & op_b;
      SLL, SLLI:   result = data_1 << shamt;
      SRL, SRLI:   result = data_1 >> shamt;
      SRA, SRAI:   result = $unsigned(a_s >>> shamt);
      LUI:         result = immediate;
      AUIPC:       result = address + immediate;
      default:     is_alu = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_mdu_unit.sv
// Integer execution unit: single-cycle ALU plus iterative shift-add multiply
// and restoring divide, behind a valid/ready handshake with ROB tag carry.
module alu_mdu_unit
  import alu_mdu_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  instr_name_e          i_instr_name,
  input  logic [XLEN-1:0]      i_data_1,
  input  logic [XLEN-1:0]      i_data_2,
  input  logic [XLEN-1:0]      i_address,
  input  logic [XLEN-1:0]      i_immediate,
  input  logic [TAG_WIDTH-1:0] i_tag,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [XLEN-1:0]      o_result,
  output logic [TAG_WIDTH-1:0] o_tag
);

  localparam int                PW       = 2 * XLEN;
  localparam int                CNT_W    = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]   INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] sign_fix(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

  function automatic logic [PW-1:0] sign_fix_wide(input logic [PW-1:0] v, input logic neg);
    return neg ? (~v + PW'(1)) : v;
  endfunction

  alu_mdu_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  logic [XLEN-1:0]  alu_result;
  logic             alu_hit;
  logic             mul_op, div_op, iterative, busy, accept;
  logic             sgn_a, sgn_b, sa, sb;
  logic             div_zero, div_ovf, mdu_short;
  logic             neg_d, sel_hi_d;
  logic [XLEN-1:0]  mag_a, mag_b, short_result, accept_result;

  logic [XLEN-1:0]  hi_p1, lo_p1, opb_p1;
  logic             neg_p1, sel_hi_p1;
  logic [XLEN:0]    mul_sum, div_trial;
  logic [XLEN-1:0]  hi_step, lo_step, final_result;
  logic [PW-1:0]    prod_fix;

  alu_core #(.XLEN(XLEN)) u_alu_core (
    .instr_name (i_instr_name),
    .data_1     (i_data_1),
    .data_2     (i_data_2),
    .address    (i_address),
    .immediate  (i_immediate),
    .result     (alu_result),
    .is_alu     (alu_hit)
  );

  // Accept-stage decode: operand signedness, magnitudes and short-circuits
  assign mul_op = is_mul_op(i_instr_name);
  assign div_op = is_div_op(i_instr_name);

  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (i_instr_name)
      MULH, DIV, REM: begin sgn_a = 1'b1; sgn_b = 1'b1; end
      MULHSU:         sgn_a = 1'b1;
      default:        ;
    endcase
  end

  assign sa    = sgn_a & i_data_1[XLEN-1];
  assign sb    = sgn_b & i_data_2[XLEN-1];
  assign mag_a = sign_fix(i_data_1, sa);
  assign mag_b = sign_fix(i_data_2, sb);

  assign div_zero  = div_op && (i_data_2 == '0);
  assign div_ovf   = ((i_instr_name == DIV) || (i_instr_name == REM)) &&
                     (i_data_1 == INT_MIN) && (i_data_2 == '1);
  assign mdu_short = div_zero || div_ovf;
  assign iterative = mul_op || (div_op && !mdu_short);

  assign sel_hi_d = (i_instr_name == MULH) || (i_instr_name == MULHSU) ||
                    (i_instr_name == MULHU) || (i_instr_name == REM) || (i_instr_name == REMU);
  assign neg_d    = ((i_instr_name == REM) || (i_instr_name == REMU)) ? sa : (sa ^ sb);

  always_comb begin
    short_result = '0;
    case (i_instr_name)
      DIV, DIVU: short_result = div_zero ? '1 : i_data_1;
      REM, REMU: short_result = div_zero ? i_data_1 : '0;
      default:   short_result = '0;
    endcase
  end

  // Unsupported operations fall through to zero
  assign accept_result = alu_hit ? alu_result : (mdu_short ? short_result : '0);

  // Handshake and FSM
  assign busy    = (state_q == BUSY_MUL) || (state_q == BUSY_DIV);
  assign o_ready = (state_q == IDLE) || ((state_q == DONE) && i_ready);
  assign accept  = i_valid && o_ready && !i_flush;
  assign o_valid = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            if (mul_op)         state_d = BUSY_MUL;
            else if (iterative) state_d = BUSY_DIV;
            else                state_d = DONE;
          end else if ((state_q == DONE) && i_ready) begin
            state_d = IDLE;
          end
        end
        BUSY_MUL, BUSY_DIV: if (cnt_q == CNT_ONE) state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Iteration stage: one shift-add or one restoring-subtract step per edge
  always_comb begin
    mul_sum   = {1'b0, hi_p1} + (lo_p1[0] ? {1'b0, opb_p1} : '0);
    div_trial = {hi_p1, lo_p1[XLEN-1]};
    if (state_q == BUSY_MUL) begin
      hi_step = mul_sum[XLEN:1];
      lo_step = {mul_sum[0], lo_p1[XLEN-1:1]};
    end else if (div_trial >= {1'b0, opb_p1}) begin
      hi_step = div_trial[XLEN-1:0] - opb_p1;
      lo_step = {lo_p1[XLEN-2:0], 1'b1};
    end else begin
      hi_step = div_trial[XLEN-1:0];
      lo_step = {lo_p1[XLEN-2:0], 1'b0};
    end
  end

  assign prod_fix     = sign_fix_wide({hi_step, lo_step}, neg_p1);
  assign final_result = (state_q == BUSY_MUL) ?
                        (sel_hi_p1 ? prod_fix[PW-1:XLEN] : prod_fix[XLEN-1:0]) :
                        sign_fix(sel_hi_p1 ? hi_step : lo_step, neg_p1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      o_result <= '0;
      o_tag    <= '0;
    end else begin
      state_q <= state_d;
      if (i_flush) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= iterative ? CNT_LOAD : '0;
        o_tag <= i_tag;
        if (!iterative) o_result <= accept_result;
      end else if (busy) begin
        cnt_q <= cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) o_result <= final_result;
      end
    end
  end

  // Operand/partial-result registers carry no reset; the FSM qualifies them
  always_ff @(posedge i_clk) begin
    if (accept && iterative) begin
      hi_p1     <= '0;
      lo_p1     <= mag_a;
      opb_p1    <= mag_b;
      neg_p1    <= neg_d;
      sel_hi_p1 <= sel_hi_d;
    end else if (busy) begin
      hi_p1 <= hi_step;
      lo_p1 <= lo_step;
    end
  end

endmodule

// File: tb/tb_alu_mdu_unit.sv
// Directed self-checking bench for alu_mdu_unit (XLEN=32 and XLEN=64 builds).
module tb_alu_mdu_unit;
  import alu_mdu_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, valid, dut_ready, res_valid, res_ready;
  instr_name_e op;
  logic [31:0] d1, d2, pc, imm, res;
  logic [5:0]  tag, res_tag;

  logic        flush64, valid64, dut_ready64, res_valid64, res_ready64;
  instr_name_e op64;
  logic [63:0] a64, b64, pc64, imm64, res64;
  logic [5:0]  tag64, res_tag64;

  int checks = 0;
  int errors = 0;

  typedef struct {
    instr_name_e op;
    logic [31:0] a, b, im, p, exp;
    int          lat;
  } vec_t;

  always #5 clk = ~clk;

  alu_mdu_unit #(.XLEN(32), .TAG_WIDTH(6)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(dut_ready),
    .i_instr_name(op), .i_data_1(d1), .i_data_2(d2), .i_address(pc), .i_immediate(imm),
    .i_tag(tag), .o_valid(res_valid), .i_ready(res_ready), .o_result(res), .o_tag(res_tag)
  );

  alu_mdu_unit #(.XLEN(64), .TAG_WIDTH(6)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush64), .i_valid(valid64), .o_ready(dut_ready64),
    .i_instr_name(op64), .i_data_1(a64), .i_data_2(b64), .i_address(pc64), .i_immediate(imm64),
    .i_tag(tag64), .o_valid(res_valid64), .i_ready(res_ready64), .o_result(res64), .o_tag(res_tag64)
  );

  task automatic set_op(input instr_name_e o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [31:0] p, input logic [5:0] t);
    op = o; d1 = a; d2 = b; imm = im; pc = p; tag = t; valid = 1'b1;
  endtask

  // Offer one op (DUT idle, result not consumed) and count cycles until o_valid; 0 = timeout
  task automatic run_op(input instr_name_e o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [31:0] p, input logic [5:0] t,
                        output int lat);
    set_op(o, a, b, im, p, t);
    @(posedge clk); #1;
    valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      if (res_valid) begin lat = i; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic run_op64(input instr_name_e o, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] im, output int lat);
    op64 = o; a64 = a; b64 = b; imm64 = im; pc64 = '0; tag64 = 6'd50; valid64 = 1'b1;
    @(posedge clk); #1;
    valid64 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      if (res_valid64) begin lat = i; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", res_valid); end
    checks++; if (dut_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", dut_ready); end
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", res); end
    checks++; if (res_tag !== 6'd0) begin errors++; $display("FAIL reset_tag got %0d want 0", res_tag); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b0 || dut_ready !== 1'b1) begin errors++; $display("FAIL reset_release valid=%b ready=%b want 0/1", res_valid, dut_ready); end
  endtask

  task automatic test_alu();
    vec_t v[14];
    int   lat;
    v[0]  = '{ADDI,  32'h5,         32'h0,         32'hFFFF_FFFF, 32'h0,      32'h4,         1};
    v[1]  = '{SUB,   32'h3,         32'h5,         32'h0,         32'h0,      32'hFFFF_FFFE, 1};
    v[2]  = '{SLT,   32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0,      32'h1,         1};
    v[3]  = '{SLTU,  32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0,      32'h0,         1};
    v[4]  = '{SLTIU, 32'h0,         32'h0,         32'h1,         32'h0,      32'h1,         1};
    v[5]  = '{XOR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,         32'h0,      32'h0FF0_0FF0, 1};
    v[6]  = '{ORI,   32'h0000_0F00, 32'h0,         32'h0000_00F0, 32'h0,      32'h0000_0FF0, 1};
    v[7]  = '{AND,   32'h1234_5678, 32'h0F0F_0F0F, 32'h0,         32'h0,      32'h0204_0608, 1};
    v[8]  = '{SLL,   32'h1,         32'h24,        32'h0,         32'h0,      32'h10,        1};
    v[9]  = '{SRA,   32'h8000_0000, 32'h4,         32'h0,         32'h0,      32'hF800_0000, 1};
    v[10] = '{SRLI,  32'h8000_0000, 32'h0,         32'h1F,        32'h0,      32'h1,         1};
    v[11] = '{LUI,   32'h0,         32'h0,         32'h1234_5000, 32'h0,      32'h1234_5000, 1};
    v[12] = '{AUIPC, 32'h0,         32'h0,         32'h0000_2000, 32'h1000,   32'h0000_3000, 1};
    v[13] = '{LW,    32'h1234,      32'h5678,      32'h9,         32'h0,      32'h0,         1};
    for (int i = 0; i < 14; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].im, v[i].p, 6'(i + 3), lat);
      checks++; if (res !== v[i].exp) begin errors++; $display("FAIL alu_%s result got %h want %h", v[i].op.name(), res, v[i].exp); end
      checks++; if (lat !== v[i].lat) begin errors++; $display("FAIL alu_%s latency got %0d want %0d", v[i].op.name(), lat, v[i].lat); end
      checks++; if (res_tag !== 6'(i + 3)) begin errors++; $display("FAIL alu_%s tag got %0d want %0d", v[i].op.name(), res_tag, i + 3); end
      consume();
    end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL alu_consumed valid got %b want 0", res_valid); end
  endtask

  task automatic test_mdu();
    vec_t v[10];
    int   lat;
    v[0] = '{MULH,   32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 32'h4000_0000, 33};
    v[1] = '{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF, 33};
    v[2] = '{MUL,    32'h1234_5678, 32'h10,        32'h0, 32'h0, 32'h2345_6780, 33};
    v[3] = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFE, 33};
    v[4] = '{DIV,    32'd100,       32'd7,         32'h0, 32'h0, 32'd14,        33};
    v[5] = '{DIV,    32'hFFFF_FFF9, 32'h2,         32'h0, 32'h0, 32'hFFFF_FFFD, 33};
    v[6] = '{REM,    32'hFFFF_FFF9, 32'h2,         32'h0, 32'h0, 32'hFFFF_FFFF, 33};
    v[7] = '{DIVU,   32'hFFFF_FFF9, 32'h2,         32'h0, 32'h0, 32'h7FFF_FFFC, 33};
    v[8] = '{REMU,   32'hFFFF_FFF9, 32'h2,         32'h0, 32'h0, 32'h1,         33};
    v[9] = '{REM,    32'h7,         32'hFFFF_FFFE, 32'h0, 32'h0, 32'h1,         33};
    for (int i = 0; i < 10; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].im, v[i].p, 6'(i + 20), lat);
      checks++; if (res !== v[i].exp) begin errors++; $display("FAIL mdu_%0d_%s result got %h want %h", i, v[i].op.name(), res, v[i].exp); end
      checks++; if (lat !== v[i].lat) begin errors++; $display("FAIL mdu_%0d_%s latency got %0d want %0d", i, v[i].op.name(), lat, v[i].lat); end
      checks++; if (res_tag !== 6'(i + 20)) begin errors++; $display("FAIL mdu_%0d tag got %0d want %0d", i, res_tag, i + 20); end
      consume();
    end
  endtask

  task automatic test_short_circuit();
    vec_t v[5];
    int   lat;
    v[0] = '{DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h8000_0000, 1};
    v[1] = '{REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0,         1};
    v[2] = '{REMU, 32'h7,         32'h0,         32'h0, 32'h0, 32'h7,         1};
    v[3] = '{DIVU, 32'h7,         32'h0,         32'h0, 32'h0, 32'hFFFF_FFFF, 1};
    v[4] = '{DIV,  32'h5,         32'h0,         32'h0, 32'h0, 32'hFFFF_FFFF, 1};
    for (int i = 0; i < 5; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].im, v[i].p, 6'(i + 40), lat);
      checks++; if (res !== v[i].exp) begin errors++; $display("FAIL short_%0d_%s result got %h want %h", i, v[i].op.name(), res, v[i].exp); end
      checks++; if (lat !== v[i].lat) begin errors++; $display("FAIL short_%0d_%s latency got %0d want %0d", i, v[i].op.name(), lat, v[i].lat); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(DIV, 32'd100, 32'd7, 32'h0, 32'h0, 6'd12, lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL bp_latency got %0d want 33", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (res !== 32'd14 || res_tag !== 6'd12) begin errors++; $display("FAIL bp_hold_%0d result got %h tag %0d want 0000000e tag 12", i, res, res_tag); end
      checks++; if (dut_ready !== 1'b0 || res_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_%0d ready=%b valid=%b want 0/1", i, dut_ready, res_valid); end
    end
    res_ready = 1'b1;
    set_op(ADD, 32'd2, 32'd3, 32'h0, 32'h0, 6'd13);
    @(posedge clk); #1;
    valid = 1'b0;
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b1 || res !== 32'd5 || res_tag !== 6'd13) begin errors++; $display("FAIL bp_consume_accept valid=%b result %h tag %0d want 1 00000005 13", res_valid, res, res_tag); end
    consume();
    checks++; if (res_valid !== 1'b0 || dut_ready !== 1'b1) begin errors++; $display("FAIL bp_drain valid=%b ready=%b want 0/1", res_valid, dut_ready); end
  endtask

  task automatic test_back_to_back();
    int lat;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_op(ADD, 32'(i * 10), 32'd1, 32'h0, 32'h0, 6'(i + 1));
      @(posedge clk); #1;
      checks++; if (res_valid !== 1'b1 || res !== 32'(i * 10 + 1) || res_tag !== 6'(i + 1)) begin errors++; $display("FAIL b2b_alu_%0d valid=%b result %h tag %0d want 1 %h %0d", i, res_valid, res, res_tag, 32'(i * 10 + 1), i + 1); end
      checks++; if (dut_ready !== 1'b1) begin errors++; $display("FAIL b2b_alu_ready_%0d got %b want 1", i, dut_ready); end
    end
    valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL b2b_alu_drain got %b want 0", res_valid); end
    set_op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 6'd20);
    @(posedge clk); #1;
    set_op(MUL, 32'd3, 32'd5, 32'h0, 32'h0, 6'd21);
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      if (res_valid) begin lat = i; break; end
      @(posedge clk); #1;
    end
    checks++; if (lat !== 33 || res !== 32'hFFFF_FFFE || res_tag !== 6'd20) begin errors++; $display("FAIL b2b_mdu_first lat %0d result %h tag %0d want 33 fffffffe 20", lat, res, res_tag); end
    @(posedge clk); #1;
    valid = 1'b0;
    checks++; if (res_valid !== 1'b0 || dut_ready !== 1'b0) begin errors++; $display("FAIL b2b_mdu_handover valid=%b ready=%b want 0/0", res_valid, dut_ready); end
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      if (res_valid) begin lat = i; break; end
      @(posedge clk); #1;
    end
    checks++; if (lat !== 33 || res !== 32'd15 || res_tag !== 6'd21) begin errors++; $display("FAIL b2b_mdu_second lat %0d result %h tag %0d want 33 0000000f 21", lat, res, res_tag); end
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_flush();
    int   lat;
    logic seen;
    res_ready = 1'b1;
    set_op(MUL, 32'd7, 32'd9, 32'h0, 32'h0, 6'd30);
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    set_op(SUB, 32'd1, 32'd1, 32'h0, 32'h0, 6'd31);
    @(posedge clk); #1;
    flush = 1'b0;
    valid = 1'b0;
    checks++; if (res_valid !== 1'b0 || dut_ready !== 1'b1) begin errors++; $display("FAIL flush_idle valid=%b ready=%b want 0/1", res_valid, dut_ready); end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (res_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_result got valid %b want 0", seen); end
    res_ready = 1'b0;
    run_op(SUB, 32'd3, 32'd5, 32'h0, 32'h0, 6'd32, lat);
    checks++; if (res !== 32'hFFFF_FFFE || lat !== 1 || res_tag !== 6'd32) begin errors++; $display("FAIL flush_next_sub result %h lat %0d tag %0d want fffffffe 1 32", res, lat, res_tag); end
    consume();
  endtask

  task automatic test_async_reset();
    logic seen;
    set_op(DIV, 32'd100, 32'd7, 32'h0, 32'h0, 6'd33);
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    checks++; if (dut_ready !== 1'b0) begin errors++; $display("FAIL areset_busy ready got %b want 0", dut_ready); end
    rst = 1'b1;
    #1;
    checks++; if (res_valid !== 1'b0 || dut_ready !== 1'b1 || res !== 32'h0) begin errors++; $display("FAIL areset_immediate valid=%b ready=%b result %h want 0/1/0", res_valid, dut_ready, res); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (res_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL areset_no_result got valid %b want 0", seen); end
  endtask

  task automatic test_xlen64();
    int lat;
    run_op64(SRA, 64'h8000_0000_0000_0000, 64'd63, 64'h0, lat);
    checks++; if (res64 !== 64'hFFFF_FFFF_FFFF_FFFF || lat !== 1) begin errors++; $display("FAIL x64_sra result %h lat %0d want ffffffffffffffff 1", res64, lat); end
    res_ready64 = 1'b1; @(posedge clk); #1; res_ready64 = 1'b0;
    run_op64(SLL, 64'h1, 64'h40, 64'h0, lat);
    checks++; if (res64 !== 64'h1 || lat !== 1) begin errors++; $display("FAIL x64_sll_mask result %h lat %0d want 1 1", res64, lat); end
    res_ready64 = 1'b1; @(posedge clk); #1; res_ready64 = 1'b0;
    run_op64(MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'h0, lat);
    checks++; if (res64 !== 64'h1 || lat !== 65) begin errors++; $display("FAIL x64_mulhu result %h lat %0d want 1 65", res64, lat); end
    res_ready64 = 1'b1; @(posedge clk); #1; res_ready64 = 1'b0;
    run_op64(DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, lat);
    checks++; if (res64 !== 64'h8000_0000_0000_0000 || lat !== 1 || res_tag64 !== 6'd50) begin errors++; $display("FAIL x64_div_ovf result %h lat %0d tag %0d want 8000000000000000 1 50", res64, lat, res_tag64); end
    res_ready64 = 1'b1; @(posedge clk); #1; res_ready64 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; valid = 1'b0; res_ready = 1'b0;
    op = ADD; d1 = '0; d2 = '0; pc = '0; imm = '0; tag = '0;
    flush64 = 1'b0; valid64 = 1'b0; res_ready64 = 1'b0;
    op64 = ADD; a64 = '0; b64 = '0; pc64 = '0; imm64 = '0; tag64 = '0;
    test_reset();
    test_alu();
    test_mdu();
    test_short_circuit();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_xlen64();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mdu_unit.md
# alu_mdu_unit

Parametrised integer execution unit combining the single-cycle ALU operations with an iterative RV32M/RV64M multiply/divide engine behind a valid/ready handshake. It sits between a reservation station (upstream) and the common data bus arbiter (downstream). It carries an ROB tag through so results can retire out of order. A pipeline flush discards any in-flight operation.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_WIDTH, 6, width of the ROB tag carried alongside each operation.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_flush  in  1  synchronous flush; abandons the current operation.
- i_valid  in  1  upstream offers an operation.
- o_ready  out  1  unit can accept an operation this cycle.
- i_instr_name  in  instr_name_e  operation select.
- i_data_1, i_data_2  in  XLEN  rs1 and rs2 operands.
- i_address  in  XLEN  instruction PC, used by AUIPC.
- i_immediate  in  XLEN  sign-extended immediate.
- i_tag  in  TAG_WIDTH  ROB tag.
- o_valid  out  1  result available.
- i_ready  in  1  downstream takes the result.
- o_result  out  XLEN  result.
- o_tag  out  TAG_WIDTH  tag of o_result.

## Operation
- FSM states and transitions:
  - IDLE → DONE: ALU op or MDU short-circuit case accepted.
  - IDLE → BUSY_MUL: MUL* accepted.
  - IDLE → BUSY_DIV: DIV*/REM* accepted.
  - BUSY_* → DONE: when the iteration counter reaches 0.
  - DONE → IDLE: when i_ready is high and no new op is accepted.
  - DONE → next state: when i_ready and i_valid are both high, the result is consumed and the next op is accepted on the same edge.
- o_ready = (state==IDLE) || (state==DONE && i_ready). An accept occurs when i_valid && o_ready.
- ALU ops: ADD(I), SUB, SLT(I)(U), XOR(I), OR(I), AND(I), SLL(I), SRL(I), SRA(I), LUI, AUIPC.
  - Shift amount is the low $clog2(XLEN) bits of the operand.
  - SLT-type ops produce 1 or 0, zero-extended.
  - The result is computed at accept and registered into o_result.
- MUL, MULH, MULHSU, MULHU:
  - Operands are converted to magnitudes according to signedness.
  - XLEN-iteration shift-add into a 2·XLEN product, negated at the end if the signs differ.
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
- DIV, DIVU, REM, REMU: XLEN-iteration restoring division on magnitudes.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Short-circuit cases, no iteration, straight to DONE:
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (−2^(XLEN−1) / −1): quotient = dividend; remainder = 0.
- Any instr_name outside the supported set: o_result = 0, 1-cycle path, o_valid still raised. This unit never drives Z.
- o_result and o_tag hold stable while o_valid && !i_ready.
- i_flush forces IDLE on the next edge and clears o_valid. i_flush has priority over accept and over i_ready. An operation offered in a flush cycle is not accepted.

## Timing
- Reset values: state=IDLE, o_valid=0, o_ready=1, o_result=0, o_tag=0, counter=0.
- Reset asserted mid-operation aborts it immediately (asynchronous); no result is produced.
- ALU and short-circuit latency: accept on edge k → o_valid high from edge k+1.
- MUL/DIV latency: accept on edge k → o_valid high from edge k+XLEN+1.
  - The counter loads XLEN at accept and decrements once per BUSY edge.
  - BUSY → DONE on the edge where the counter is 1.
- Throughput with i_ready held high:
  - ALU ops: one per cycle.
  - MDU ops: one per XLEN+1 cycles.
- Backpressure: while in DONE with i_ready=0, o_ready=0 and no state changes.

## Structure
- pkg_defines: extend instr_name_e with MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. Add the alu_mdu_state_e enum {IDLE, BUSY_MUL, BUSY_DIV, DONE}.
- Sub-module alu_core: purely combinational XLEN-parametrised ALU-op evaluator, instantiated once. The top level holds the FSM, the operand/tag registers and the iterative multiply/divide datapath.

## Test plan
- XLEN=32, ADDI a=0x0000_0005, imm=0xFFFF_FFFF, tag=3 → o_valid after 1 cycle, o_result=0x0000_0004, o_tag=3.
- MULH a=0x8000_0000, b=0x8000_0000 → o_valid after 33 cycles, o_result=0x4000_0000. MULHSU a=0xFFFF_FFFF, b=0xFFFF_FFFF → 0xFFFF_FFFF.
- DIV a=0x8000_0000, b=0xFFFF_FFFF → 1-cycle result 0x8000_0000. REMU a=7, b=0 → 1-cycle result 7. DIVU a=7, b=0 → 0xFFFF_FFFF.
- Backpressure: DIV 100/7 with i_ready=0 for 5 cycles after o_valid → o_result=14 held stable, o_ready=0. Then i_ready=1 plus a new ADD offered → both the consume and the accept happen on one edge.
- Flush at cycle 10 of a MUL → o_valid never rises for that tag. The next SUB 3−5 returns 0xFFFF_FFFE with 1-cycle latency.
- XLEN=64 build, SRA a=0x8000_0000_0000_0000, shamt=63 → all ones. Async reset pulse mid-DIV → o_valid=0 and o_ready=1 immediately.
